// File: rtl/sub_pipe.sv
// sub_pipe: pipelined two's-complement subtractor, diff = a - b - b_in.
// One SLICE-bit slice is resolved per stage and the carry is registered
// between stages. The flags (b_out, ovf, zero) come out with the result.
// The pipeline is globally stalled: every stage moves together, bubbles
// included, whenever the output register is empty or being consumed.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready == global advance)
//   a, b, b_in           minuend, subtrahend, borrow-in
//   out_valid/out_ready  result handshake
//   diff                 a - b - b_in mod 2^WIDTH
//   b_out                unsigned borrow (a < b + b_in)
//   ovf                  signed overflow
//   zero                 diff == 0
// WIDTH must be an integer multiple of SLICE.
module sub_pipe #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             ovf,
   output logic             zero
);

   localparam int N = WIDTH / SLICE;

   logic adv;

   genvar k;
   for (k = 0; k < N; k++) begin : g_stg
      localparam int RW = (k + 1) * SLICE;  // result bits resolved through this stage
      localparam int UW = WIDTH - RW;       // operand bits still waiting upstream

      logic [SLICE-1:0] as, bs;
      logic             ci, vi;
      logic [SLICE:0]   sum;
      logic [RW-1:0]    r_d, r_q;
      logic             v_q, c_q;

      // a - b - b_in == a + ~b + ~b_in, one slice at a time
      assign sum = {1'b0, as} + {1'b0, ~bs} + {{SLICE{1'b0}}, ci};

      if (k == 0) begin : g_src
         assign as  = a[SLICE-1:0];
         assign bs  = b[SLICE-1:0];
         assign ci  = ~b_in;
         assign vi  = in_valid & adv;
         assign r_d = sum[SLICE-1:0];
      end else begin : g_src
         assign as  = g_stg[k-1].g_up.a_q[SLICE-1:0];
         assign bs  = g_stg[k-1].g_up.b_q[SLICE-1:0];
         assign ci  = g_stg[k-1].c_q;
         assign vi  = g_stg[k-1].v_q;
         assign r_d = {sum[SLICE-1:0], g_stg[k-1].r_q};
      end

      // Only the not-yet-processed operand bits travel forward.
      if (k < N - 1) begin : g_up
         logic [UW-1:0] a_d, b_d, a_q, b_q;
         if (k == 0) begin : g_sel
            assign a_d = a[WIDTH-1:SLICE];
            assign b_d = b[WIDTH-1:SLICE];
         end else begin : g_sel
            assign a_d = g_stg[k-1].g_up.a_q[UW+SLICE-1:SLICE];
            assign b_d = g_stg[k-1].g_up.b_q[UW+SLICE-1:SLICE];
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end

      // Carry resets to 1 so that b_out (its inverse at the last stage) reads 0.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b1;
            r_q <= '0;
         end else if (adv) begin
            v_q <= vi;
            c_q <= sum[SLICE];
            r_q <= r_d;
         end
      end
   end

   // Flags are formed in the last stage, where the top slice carries the
   // operand sign bits, and registered alongside the result.
   logic ovf_d, zero_d, ovf_q, zero_q;

   assign ovf_d  = (g_stg[N-1].as[SLICE-1] != g_stg[N-1].bs[SLICE-1]) &
                   (g_stg[N-1].sum[SLICE-1] != g_stg[N-1].as[SLICE-1]);
   assign zero_d = (g_stg[N-1].r_d == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (adv) begin
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign out_valid = g_stg[N-1].v_q;
   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;
   assign diff      = g_stg[N-1].r_q;
   assign b_out     = ~g_stg[N-1].c_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule
